// File: rtl/shifter_port_ctrl.sv
// Port-decode and arbitration front end for the 8080 shift unit.
// Serves CPU and debug requesters with a req/ack handshake and one-cycle shifter strobes.
module shifter_port_ctrl #(
  parameter logic [7:0] PORT_OFFSET  = 8'h02,
  parameter logic [7:0] PORT_DATA    = 8'h04,
  parameter logic [7:0] PORT_RESULT  = 8'h03,
  parameter logic [7:0] DBG_MAX_WAIT = 8'd8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cpu_req,
  input  logic       i_cpu_wr,
  input  logic [7:0] i_cpu_port,
  input  logic [7:0] i_cpu_wdata,
  output logic       o_cpu_ack,
  output logic [7:0] o_cpu_rdata,
  input  logic       i_dbg_req,
  input  logic       i_dbg_wr,
  input  logic [7:0] i_dbg_port,
  input  logic [7:0] i_dbg_wdata,
  output logic       o_dbg_ack,
  output logic [7:0] o_dbg_rdata,
  output logic       o_sh_wr_data,
  output logic       o_sh_wr_offset,
  output logic [7:0] o_sh_data,
  input  logic [7:0] i_sh_data,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       grant_dbg_r;
  logic       wr_r;
  logic [7:0] port_r;
  logic [7:0] wdata_r;
  logic [7:0] starve_r;

  logic       pick_dbg_s;
  logic       win_wr_s;
  logic [7:0] win_port_s;
  logic [7:0] win_wdata_s;
  logic       granted_req_s;
  logic       dbg_served_s;
  logic [7:0] starve_s;
  logic       sh_wr_data_s;
  logic       sh_wr_offset_s;
  logic [7:0] sh_data_s;
  logic       cpu_ack_s;
  logic       dbg_ack_s;
  logic       busy_s;
  logic       capture_cpu_s;
  logic       capture_dbg_s;
  logic [7:0] capture_val_s;

  // Arbitration: CPU has priority unless the debug port has been starved long enough.
  always_comb begin
    pick_dbg_s = 1'b0;
    if (i_dbg_req && (!i_cpu_req || (starve_r == DBG_MAX_WAIT))) begin
      pick_dbg_s = 1'b1;
    end else begin
      pick_dbg_s = 1'b0;
    end
    if (pick_dbg_s) begin
      win_wr_s    = i_dbg_wr;
      win_port_s  = i_dbg_port;
      win_wdata_s = i_dbg_wdata;
    end else begin
      win_wr_s    = i_cpu_wr;
      win_port_s  = i_cpu_port;
      win_wdata_s = i_cpu_wdata;
    end
    granted_req_s = grant_dbg_r ? i_dbg_req : i_cpu_req;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; WAIT_LOW blocks re-service of a still-held request.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:     state_s = (i_cpu_req || i_dbg_req) ? ST_EXEC : ST_IDLE;
      ST_EXEC:     state_s = ST_ACK;
      ST_ACK:      state_s = ST_WAIT_LOW;
      ST_WAIT_LOW: state_s = granted_req_s ? ST_WAIT_LOW : ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Starvation counter for a pending debug request that is not being served.
  always_comb begin
    dbg_served_s = (state_r == ST_IDLE) ? pick_dbg_s : grant_dbg_r;
    if (!i_dbg_req || dbg_served_s) begin
      starve_s = 8'd0;
    end else if (starve_r < DBG_MAX_WAIT) begin
      starve_s = starve_r + 8'd1;
    end else begin
      starve_s = starve_r;
    end
  end

  // Latch the winning request fields when leaving IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_dbg_r <= 1'b0;
      wr_r        <= 1'b0;
      port_r      <= 8'h00;
      wdata_r     <= 8'h00;
      starve_r    <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) && (i_cpu_req || i_dbg_req)) begin
        grant_dbg_r <= pick_dbg_s;
        wr_r        <= win_wr_s;
        port_r      <= win_port_s;
        wdata_r     <= win_wdata_s;
      end else begin
        grant_dbg_r <= grant_dbg_r;
        wr_r        <= wr_r;
        port_r      <= port_r;
        wdata_r     <= wdata_r;
      end
      starve_r <= starve_s;
    end
  end

  // Output decode: next values of the registered outputs, so strobes land exactly in EXEC.
  always_comb begin
    sh_wr_data_s   = (state_s == ST_EXEC) && win_wr_s && (win_port_s == PORT_DATA);
    sh_wr_offset_s = (state_s == ST_EXEC) && win_wr_s && (win_port_s == PORT_OFFSET);
    sh_data_s      = (state_s == ST_EXEC) ? win_wdata_s : o_sh_data;
    cpu_ack_s      = (state_s == ST_ACK) && !grant_dbg_r;
    dbg_ack_s      = (state_s == ST_ACK) && grant_dbg_r;
    busy_s         = (state_s != ST_IDLE);
    capture_cpu_s  = (state_r == ST_EXEC) && !wr_r && !grant_dbg_r;
    capture_dbg_s  = (state_r == ST_EXEC) && !wr_r && grant_dbg_r;
    capture_val_s  = (port_r == PORT_RESULT) ? i_sh_data : 8'h00;
  end

  // Output registers; read data holds until that requester's next read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sh_wr_data   <= 1'b0;
      o_sh_wr_offset <= 1'b0;
      o_sh_data      <= 8'h00;
      o_cpu_ack      <= 1'b0;
      o_dbg_ack      <= 1'b0;
      o_busy         <= 1'b0;
      o_cpu_rdata    <= 8'h00;
      o_dbg_rdata    <= 8'h00;
    end else begin
      o_sh_wr_data   <= sh_wr_data_s;
      o_sh_wr_offset <= sh_wr_offset_s;
      o_sh_data      <= sh_data_s;
      o_cpu_ack      <= cpu_ack_s;
      o_dbg_ack      <= dbg_ack_s;
      o_busy         <= busy_s;
      o_cpu_rdata    <= capture_cpu_s ? capture_val_s : o_cpu_rdata;
      o_dbg_rdata    <= capture_dbg_s ? capture_val_s : o_dbg_rdata;
    end
  end

endmodule
